// File: rtl/serial_to_parallel_pkg.sv
// ============================================================================
// Module : serial_to_parallel_pkg
// Brief  : Shared state encoding and counter-width helper for the deserializer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_to_parallel_pkg;

    typedef enum logic [0:0] {
        RECV = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int calc_cw(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_to_parallel_bank.sv
// ============================================================================
// Module : serial_to_parallel_bank
// Brief  : M x N slot registers written one at a time by index, read flattened.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_to_parallel_bank #(
    parameter int N  = 32,
    parameter int M  = 8,
    parameter int CW = 3
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           i_we,
    input  logic [CW-1:0]  i_idx,
    input  logic [N-1:0]   i_data,
    output logic [M*N-1:0] o_flat
);

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_slot
            logic [N-1:0] r_slot;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_slot <= '0;
                end else if (i_we && (i_idx == CW'(gi))) begin
                    r_slot <= i_data;
                end
            end

            assign o_flat[gi*N +: N] = r_slot;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/serial_to_parallel.sv
// ============================================================================
// Module : serial_to_parallel
// Brief  : Collects M N-bit val/rdy words into one M*N-bit val/rdy beat.
//          SERIAL_TO_PARALLEL_OVERLAP_EN enables zero-bubble SEND->RECV turnaround.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter  int N  = 32,
    parameter  int M  = 8,
    localparam int CW = calc_cw(M)
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           recv_val,
    output logic           recv_rdy,
    input  logic [N-1:0]   recv_msg,
    output logic           send_val,
    input  logic           send_rdy,
    output logic [M*N-1:0] send_msg,
    output logic [CW-1:0]  count
);

    state_e        r_state;
    logic [CW-1:0] r_count;
    logic          r_live;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_last;

    // r_live keeps recv_rdy low during reset and until the first clean edge
    assign send_val = (r_state == SEND);
`ifdef SERIAL_TO_PARALLEL_OVERLAP_EN
    assign recv_rdy = r_live & ((r_state == RECV) | send_rdy);
`else
    assign recv_rdy = r_live & (r_state == RECV);
`endif

    assign w_in_fire  = recv_val & recv_rdy;
    assign w_out_fire = send_val & send_rdy;
    assign w_last     = (r_count == CW'(M - 1));
    assign count      = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live  <= 1'b0;
            r_state <= RECV;
            r_count <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                RECV: begin
                    if (w_in_fire) begin
                        if (w_last) begin
                            r_count <= '0;
                            r_state <= SEND;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (w_out_fire) begin
                        r_state <= RECV;
                        r_count <= '0;
`ifdef SERIAL_TO_PARALLEL_OVERLAP_EN
                        // Word accepted alongside the output lands in slot 0
                        if (w_in_fire) begin
                            if (M == 1) begin
                                r_state <= SEND;
                            end else begin
                                r_count <= CW'(1);
                            end
                        end
`endif
                    end
                end
                default: r_state <= RECV;
            endcase
        end
    end

    serial_to_parallel_bank #(
        .N  (N),
        .M  (M),
        .CW (CW)
    ) u_bank (
        .clk    (clk),
        .reset  (reset),
        .i_we   (w_in_fire),
        .i_idx  (r_count),
        .i_data (recv_msg),
        .o_flat (send_msg)
    );

endmodule

`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
// ============================================================================
// Module : tb_serial_to_parallel
// Brief  : Scoreboard bench for serial_to_parallel (M=4/N=8, M=1/N=16, M=2/N=8).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_to_parallel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- DUT A: M=4, N=8 ----------------
    logic        a_recv_val, a_recv_rdy, a_send_val, a_send_rdy;
    logic [7:0]  a_recv_msg;
    logic [31:0] a_send_msg;
    logic [1:0]  a_count;
    logic [31:0] qa[$];
    int          a_fires = 0;

    serial_to_parallel #(.N(8), .M(4)) u_a (
        .clk(clk), .reset(rst_n),
        .recv_val(a_recv_val), .recv_rdy(a_recv_rdy), .recv_msg(a_recv_msg),
        .send_val(a_send_val), .send_rdy(a_send_rdy), .send_msg(a_send_msg),
        .count(a_count)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && a_send_val && a_send_rdy) begin
            check("a_expected_out", qa.size() != 0, 1);
            if (qa.size() != 0) check("a_send_msg", a_send_msg, qa.pop_front());
            a_fires++;
        end
    end

    // ---------------- DUT B: M=1, N=16 ----------------
    logic        b_recv_val, b_recv_rdy, b_send_val, b_send_rdy;
    logic [15:0] b_recv_msg;
    logic [15:0] b_send_msg;
    logic [0:0]  b_count;
    logic [15:0] qb[$];
    int          b_fire_cyc[$];

    serial_to_parallel #(.N(16), .M(1)) u_b (
        .clk(clk), .reset(rst_n),
        .recv_val(b_recv_val), .recv_rdy(b_recv_rdy), .recv_msg(b_recv_msg),
        .send_val(b_send_val), .send_rdy(b_send_rdy), .send_msg(b_send_msg),
        .count(b_count)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && b_send_val && b_send_rdy) begin
            check("b_expected_out", qb.size() != 0, 1);
            if (qb.size() != 0) check("b_send_msg", b_send_msg, qb.pop_front());
            b_fire_cyc.push_back(cyc);
        end
    end

`ifdef SERIAL_TO_PARALLEL_OVERLAP_EN
    // ---------------- DUT C: M=2, N=8 ----------------
    logic        c_recv_val, c_recv_rdy, c_send_val, c_send_rdy;
    logic [7:0]  c_recv_msg;
    logic [15:0] c_send_msg;
    logic [0:0]  c_count;
    logic [15:0] qc[$];
    int          c_fires = 0;

    serial_to_parallel #(.N(8), .M(2)) u_c (
        .clk(clk), .reset(rst_n),
        .recv_val(c_recv_val), .recv_rdy(c_recv_rdy), .recv_msg(c_recv_msg),
        .send_val(c_send_val), .send_rdy(c_send_rdy), .send_msg(c_send_msg),
        .count(c_count)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && c_send_val && c_send_rdy) begin
            check("c_expected_out", qc.size() != 0, 1);
            if (qc.size() != 0) check("c_send_msg", c_send_msg, qc.pop_front());
            c_fires++;
        end
    end

    task automatic send_c(input logic [7:0] d, output int n);
        logic fired = 1'b0;
        n = 0;
        c_recv_val = 1'b1;
        c_recv_msg = d;
        while (!fired && n < 20) begin
            @(negedge clk); fired = c_recv_rdy;
            @(posedge clk); #1; n++;
        end
        check("c_in_accepted", fired, 1);
    endtask
`endif

    // Each send task starts and returns at posedge+1; val is left high
    task automatic send_a(input logic [7:0] d);
        int   n     = 0;
        logic fired = 1'b0;
        a_recv_val = 1'b1;
        a_recv_msg = d;
        while (!fired && n < 20) begin
            @(negedge clk); fired = a_recv_rdy;
            @(posedge clk); #1; n++;
        end
        check("a_in_accepted", fired, 1);
    endtask

    task automatic send_b(input logic [15:0] d, output int n);
        logic fired = 1'b0;
        n = 0;
        b_recv_val = 1'b1;
        b_recv_msg = d;
        while (!fired && n < 20) begin
            @(negedge clk); fired = b_recv_rdy;
            @(posedge clk); #1; n++;
        end
        check("b_in_accepted", fired, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb1, wb2;
        rst_n      = 1'b0;
        a_recv_val = 1'b0; a_recv_msg = '0; a_send_rdy = 1'b0;
        b_recv_val = 1'b0; b_recv_msg = '0; b_send_rdy = 1'b0;
`ifdef SERIAL_TO_PARALLEL_OVERLAP_EN
        c_recv_val = 1'b0; c_recv_msg = '0; c_send_rdy = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_send_val", a_send_val, 0);
        check("rst_recv_rdy", a_recv_rdy, 0);
        check("rst_count",    a_count,    0);
        check("rst_send_msg", a_send_msg, 0);
        check("rst_b_recv_rdy", b_recv_rdy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_recv_rdy",   a_recv_rdy, 1);
        check("post_rst_b_recv_rdy", b_recv_rdy, 1);

        // Fill
        a_send_rdy = 1'b1;
        qa.push_back(32'h44332211);
        send_a(8'h11); send_a(8'h22); send_a(8'h33); send_a(8'h44);
        a_recv_val = 1'b0;
        check("fill_send_val", a_send_val, 1);
        check("fill_send_msg", a_send_msg, 32'h44332211);
`ifndef SERIAL_TO_PARALLEL_OVERLAP_EN
        check("fill_recv_rdy", a_recv_rdy, 0);
`endif
        @(posedge clk); #1;
        check("fill_after_send_val", a_send_val, 0);
        check("fill_after_count",    a_count,    0);
        check("fill_after_recv_rdy", a_recv_rdy, 1);
        check("fill_fires",          a_fires,    1);

        // Back-pressure
        a_send_rdy = 1'b0;
        qa.push_back(32'h88776655);
        send_a(8'h55); send_a(8'h66); send_a(8'h77); send_a(8'h88);
        a_recv_msg = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            check("bp_send_msg", a_send_msg, 32'h88776655);
            check("bp_recv_rdy", a_recv_rdy, 0);
            check("bp_send_val", a_send_val, 1);
            @(posedge clk); #1;
        end
        a_recv_val = 1'b0;
        a_send_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_release_send_val", a_send_val, 0);
        check("bp_fires",            a_fires,    2);

        // Input gaps
        qa.push_back(32'hA3A2A1A0);
        check("gap_count_start", a_count, 0);
        for (int i = 0; i < 4; i++) begin
            a_recv_val = 1'b1;
            a_recv_msg = 8'hA0 + 8'(i);
            @(posedge clk); #1;
            check("gap_count_fire", a_count, (i + 1) % 4);
            if (i < 3) begin
                a_recv_val = 1'b0;
                @(posedge clk); #1;
                check("gap_count_idle", a_count, i + 1);
            end
        end
        check("gap_send_val", a_send_val, 1);
        a_recv_val = 1'b0;
        @(posedge clk); #1;
        check("gap_fires", a_fires, 3);

        // Reset mid-frame
        send_a(8'hDE); send_a(8'hAD);
        a_recv_val = 1'b0;
        check("mid_count_pre", a_count, 2);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_count",    a_count,    0);
        check("mid_rst_send_msg", a_send_msg, 0);
        check("mid_rst_send_val", a_send_val, 0);
        check("mid_rst_recv_rdy", a_recv_rdy, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        qa.push_back(32'h04030201);
        send_a(8'h01); send_a(8'h02); send_a(8'h03); send_a(8'h04);
        a_recv_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_fires", a_fires, 4);

        // M=1
        b_send_rdy = 1'b1;
        qb.push_back(16'hBEEF);
        qb.push_back(16'hCAFE);
        send_b(16'hBEEF, wb1);
        check("m1_send_val", b_send_val, 1);
        check("m1_count",    b_count,    0);
        send_b(16'hCAFE, wb2);
        b_recv_val = 1'b0;
`ifdef SERIAL_TO_PARALLEL_OVERLAP_EN
        check("m1_second_wait", wb2, 1);
`else
        check("m1_second_wait", wb2, 2);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("m1_fires", b_fire_cyc.size(), 2);
        if (b_fire_cyc.size() >= 2) begin
`ifdef SERIAL_TO_PARALLEL_OVERLAP_EN
            check("m1_fire_spacing", b_fire_cyc[1] - b_fire_cyc[0], 1);
`else
            check("m1_fire_spacing", b_fire_cyc[1] - b_fire_cyc[0], 2);
`endif
        end
        check("m1_count_end", b_count, 0);

`ifdef SERIAL_TO_PARALLEL_OVERLAP_EN
        // Overlap, M=2
        begin
            int wc;
            c_send_rdy = 1'b1;
            qc.push_back(16'h0201);
            qc.push_back(16'h0403);
            for (int i = 1; i <= 4; i++) begin
                send_c(8'(i), wc);
                check("ov_no_stall", wc, 1);
            end
            c_recv_val = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("ov_fires", c_fires, 2);
            check("ov_queue_empty", qc.size(), 0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
